counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 SHALL have parameter MOD_MAX, default 11: highest value of the controlled mod-12 counter (the counter wraps 11->0 up and 0->11 down).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-006 SHALL have port cmd_start  input  4  value the counter is loaded with.
REQ-007 SHALL have port cmd_target  input  4  value at which the counter must stop.
REQ-008 SHALL have port cmd_dir  input  1  0 = count up, 1 = count down.
REQ-009 SHALL have port abort  input  1  terminate the current run.
REQ-010 SHALL have port cnt_reset  output  1  drives counter reset (active-high, synchronous at counter).
REQ-011 SHALL have port cnt_load  output  1  drives counter load.
REQ-012 SHALL have port cnt_mode  output  1  drives counter mode.
REQ-013 SHALL have port cnt_data_in  output  4  drives counter data_in.
REQ-014 SHALL have port cnt_value  input  4  counter data_out.
REQ-015 SHALL have ports busy, done, cmd_err, mismatch  output  1 each, and steps  output  4  (cycles counted in the current or last run).

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN; every output SHALL be decoded from registered state only (no combinational path from cnt_value or cmd_* to cnt_* outputs).
REQ-017 SHALL, in IDLE: cmd_ready=1, busy=0, cnt_load=1, cnt_data_in=hold (freezes the counter at hold), cnt_mode=0.
REQ-018 SHALL accept a command when cmd_valid & cmd_ready; if cmd_start>MOD_MAX or cmd_target>MOD_MAX it SHALL pulse cmd_err for one cycle (next cycle) and remain IDLE; otherwise it SHALL latch start/target/dir, clear steps and mismatch, and enter LOAD.
REQ-019 SHALL, in LOAD: cmd_ready=0, busy=1, cnt_load=1, cnt_data_in=start, cnt_mode=dir; shadow<=start; next state RUN.
REQ-020 SHALL, in RUN with shadow!=target: cnt_load=0, cnt_mode=dir; shadow SHALL step +1/-1 with the same wrap rule as the counter (11->0 up, 0->11 down); steps<=steps+1.
REQ-021 SHALL, in RUN with shadow==target: cnt_load=1, cnt_data_in=target, done=1 for that cycle, hold<=target, next state IDLE.
REQ-022 SHALL give done at cycle LOAD+1+d, where d is the modular distance from start to target in dir (0..11); steps SHALL equal d while done=1 and hold that value until the next accepted command.
REQ-023 SHALL, in RUN, set sticky mismatch when cnt_value!=shadow (compared on the same edge the shadow updates); mismatch SHALL NOT alter sequencing.
REQ-024 SHALL, on abort=1 in LOAD or RUN: cnt_load=1, cnt_data_in=shadow (start if in LOAD), hold<=that value, next state IDLE, done=0; abort in IDLE SHALL be ignored.
REQ-025 SHALL give abort priority over target match in the same RUN cycle.
REQ-026 SHALL ignore cmd_valid while busy (cmd_ready=0); no command queuing.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force: state=IDLE, hold=0, shadow=0, steps=0, done=0, cmd_err=0, mismatch=0, cnt_reset=1.
REQ-028 SHALL clear cnt_reset on the first rising clk edge after reset_n deasserts, so the counter sees exactly one synchronous reset edge; cnt_reset SHALL then stay 0.
REQ-029 SHALL, on reset_n asserted mid-run, abandon the run without done and restart in IDLE holding 0.

Verification
REQ-030 SHALL cover: start=3, target=7, dir=0 -> LOAD then 4 RUN steps, done at cycle 6 after accept, steps=4, counter frozen at 7.
REQ-031 SHALL cover: start=1, target=10, dir=1 -> down-wrap 1,0,11,10; done with steps=3; cnt_value stays 10 in IDLE.
REQ-032 SHALL cover: start=5, target=5 -> done on first RUN cycle, steps=0.
REQ-033 SHALL cover: target=12 -> cmd_err one-cycle pulse, no LOAD, counter unchanged.
REQ-034 SHALL cover: start=0, target=11, dir=0, abort after 4 RUN cycles -> IDLE, no done, counter frozen at 4, steps=4.
REQ-035 SHALL cover: reset_n low mid-run, and cnt_value forced off-sequence -> all outputs per REQ-027, cnt_reset one edge; mismatch=1 sticky.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequences an external mod-(MOD_MAX+1) up/down counter from
// a start value to a target value. A shadow copy of the count is tracked
// internally; the counter output is checked against it for a sticky mismatch.
module counter_seq_ctrl #(
  parameter logic [3:0] MOD_MAX = 4'd11
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_start,
  input  logic [3:0] cmd_target,
  input  logic       cmd_dir,
  input  logic       abort,
  output logic       cnt_reset,
  output logic       cnt_load,
  output logic       cnt_mode,
  output logic [3:0] cnt_data_in,
  input  logic [3:0] cnt_value,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic       mismatch,
  output logic [3:0] steps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [3:0] r_start;
  logic [3:0] r_target;
  logic       r_dir;
  logic [3:0] r_shadow;
  logic [3:0] r_hold;
  logic [3:0] r_steps;
  logic       r_cmd_err;
  logic       r_mismatch;
  logic       r_cnt_reset;

  logic       w_match;
  logic       w_bad_cmd;
  logic       w_accept;
  logic       w_step;
  logic       w_to_idle;
  logic [3:0] w_final_val;
  logic [3:0] w_shadow_nxt;

  assign w_match = (r_shadow == r_target);

  // Shadow advances one position in the run direction, wrapping at MOD_MAX.
  always_comb begin
    if (r_dir) begin
      w_shadow_nxt = (r_shadow == 4'd0) ? MOD_MAX : r_shadow - 4'd1;
    end else begin
      w_shadow_nxt = (r_shadow == MOD_MAX) ? 4'd0 : r_shadow + 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values, independent of block ordering.
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; counter drives depend only on registered
  // state plus the abort request.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    cnt_load    = 1'b1;
    cnt_mode    = 1'b0;
    cnt_data_in = r_hold;
    done        = 1'b0;
    w_bad_cmd   = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_to_idle   = 1'b0;
    w_final_val = r_hold;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          if ((cmd_start > MOD_MAX) || (cmd_target > MOD_MAX)) begin
            w_bad_cmd = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        cnt_data_in = r_start;
        cnt_mode    = r_dir;
        if (abort) begin
          w_to_idle   = 1'b1;
          w_final_val = r_start;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        cnt_mode = r_dir;
        if (abort) begin
          // Abort wins over a target match in the same cycle.
          cnt_data_in = r_shadow;
          w_to_idle   = 1'b1;
          w_final_val = r_shadow;
          w_state_nxt = S_IDLE;
        end else if (w_match) begin
          cnt_data_in = r_target;
          done        = 1'b1;
          w_to_idle   = 1'b1;
          w_final_val = r_target;
          w_state_nxt = S_IDLE;
        end else begin
          cnt_load    = 1'b0;
          cnt_data_in = r_shadow;
          w_step      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch, shadow tracking, step count, hold value and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start     <= 4'd0;
      r_target    <= 4'd0;
      r_dir       <= 1'b0;
      r_shadow    <= 4'd0;
      r_hold      <= 4'd0;
      r_steps     <= 4'd0;
      r_cmd_err   <= 1'b0;
      r_mismatch  <= 1'b0;
      r_cnt_reset <= 1'b1;
    end else begin
      // The counter sees exactly one reset edge after reset_n releases.
      r_cnt_reset <= 1'b0;
      r_cmd_err   <= w_bad_cmd;
      if (w_accept) begin
        r_start    <= cmd_start;
        r_target   <= cmd_target;
        r_dir      <= cmd_dir;
        r_steps    <= 4'd0;
        r_mismatch <= 1'b0;
      end
      if (r_state == S_LOAD) begin
        r_shadow <= r_start;
      end
      if (w_step) begin
        r_shadow <= w_shadow_nxt;
        r_steps  <= r_steps + 4'd1;
      end
      if ((r_state == S_RUN) && (cnt_value != r_shadow)) begin
        r_mismatch <= 1'b1;
      end
      if (w_to_idle) begin
        r_hold <= w_final_val;
      end
    end
  end

  assign cnt_reset = r_cnt_reset;
  assign cmd_err   = r_cmd_err;
  assign mismatch  = r_mismatch;
  assign steps     = r_steps;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: drives counter_seq_ctrl with an attached behavioural
// mod-12 counter and checks runs against arithmetic expectations.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_start = 4'd0;
  logic [3:0] cmd_target = 4'd0;
  logic       cmd_dir = 1'b0;
  logic       abort = 1'b0;
  logic       cnt_reset;
  logic       cnt_load;
  logic       cnt_mode;
  logic [3:0] cnt_data_in;
  logic [3:0] cnt_value;
  logic       busy;
  logic       done;
  logic       cmd_err;
  logic       mismatch;
  logic [3:0] steps;

  logic       force_req = 1'b0;
  logic [3:0] force_val = 4'd0;

  int checks = 0;
  int failures = 0;

  int         obs_done_at;
  int         obs_done_cnt;
  int         obs_err_at;
  int         obs_err_cnt;
  int         obs_busy_cnt;
  int         obs_ready_bad;
  logic [3:0] obs_steps_done;
  logic [3:0] obs_final_val;
  logic [3:0] obs_final_steps;
  logic       obs_final_mm;
  logic [3:0] obs_seq[$];

  logic [3:0] exp_hold;
  logic [3:0] exp_steps;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.MOD_MAX(4'd11)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_target (cmd_target),
    .cmd_dir    (cmd_dir),
    .abort      (abort),
    .cnt_reset  (cnt_reset),
    .cnt_load   (cnt_load),
    .cnt_mode   (cnt_mode),
    .cnt_data_in(cnt_data_in),
    .cnt_value  (cnt_value),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err),
    .mismatch   (mismatch),
    .steps      (steps)
  );

  // External mod-12 counter; force_req lets the bench knock it off sequence.
  always @(posedge clk) begin
    if (cnt_reset) cnt_value <= 4'd0;
    else if (force_req) cnt_value <= force_val;
    else if (cnt_load) cnt_value <= cnt_data_in;
    else if (cnt_mode) cnt_value <= (cnt_value == 4'd0) ? 4'd11 : cnt_value - 4'd1;
    else cnt_value <= (cnt_value == 4'd11) ? 4'd0 : cnt_value + 4'd1;
  end

  // Modular distance from s to t in direction d.
  function automatic int dist12(input int s, input int t, input bit d);
    return d ? ((s - t + 12) % 12) : ((t - s + 12) % 12);
  endfunction

  // Position reached after n steps from s in direction d.
  function automatic int walk12(input int s, input bit d, input int n);
    return d ? (((s - n) % 12 + 12) % 12) : ((s + n) % 12);
  endfunction

  // Issue one command and observe 16 cycles after the accept cycle (cycle 0).
  task automatic do_cmd(input logic [3:0] s, input logic [3:0] t, input logic d,
                        input int abort_cyc, input int force_cyc, input bit junk);
    bit stopped;
    stopped        = 1'b0;
    obs_done_at    = -1;
    obs_done_cnt   = 0;
    obs_err_at     = -1;
    obs_err_cnt    = 0;
    obs_busy_cnt   = 0;
    obs_ready_bad  = 0;
    obs_steps_done = 4'd0;
    obs_seq.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = s; cmd_target = t; cmd_dir = d; abort = 1'b0;
    #1;
    if (!cmd_ready) obs_ready_bad++;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      force_req = (c == force_cyc);
      force_val = 4'd9;
      abort     = (c == abort_cyc);
      if (abort) stopped = 1'b1;
      cmd_valid  = junk && !stopped;
      cmd_start  = 4'($urandom_range(0, 15));
      cmd_target = 4'($urandom_range(0, 15));
      cmd_dir    = 1'($urandom_range(0, 1));
      #1;
      if (busy && cmd_ready) obs_ready_bad++;
      if (busy) obs_busy_cnt++;
      if (busy && c >= 2) obs_seq.push_back(cnt_value);
      if (done) begin
        obs_done_cnt++;
        if (obs_done_at < 0) begin
          obs_done_at    = c;
          obs_steps_done = steps;
        end
        stopped = 1'b1;
      end
      if (cmd_err) begin
        obs_err_cnt++;
        if (obs_err_at < 0) obs_err_at = c;
      end
    end
    abort = 1'b0; cmd_valid = 1'b0; force_req = 1'b0;
    obs_final_val   = cnt_value;
    obs_final_steps = steps;
    obs_final_mm    = mismatch;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cnt_reset !== 1'b1) begin failures++; $display("FAIL rst_cnt_reset got=%b exp=1", cnt_reset); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_busy_ready got=%b%b exp=01", busy, cmd_ready); end
    checks++; if (done !== 1'b0 || cmd_err !== 1'b0 || mismatch !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", done, cmd_err, mismatch); end
    checks++; if (steps !== 4'd0) begin failures++; $display("FAIL rst_steps got=%0d exp=0", steps); end
    checks++; if (cnt_load !== 1'b1 || cnt_mode !== 1'b0 || cnt_data_in !== 4'd0) begin failures++; $display("FAIL rst_cnt_drive got=%b%b/%0d exp=10/0", cnt_load, cnt_mode, cnt_data_in); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (cnt_reset !== 1'b1) begin failures++; $display("FAIL rel_cnt_reset_before_edge got=%b exp=1", cnt_reset); end
    @(posedge clk); #1;
    checks++; if (cnt_reset !== 1'b0) begin failures++; $display("FAIL rel_cnt_reset_after_edge got=%b exp=0", cnt_reset); end
    repeat (4) @(posedge clk); #1;
    checks++; if (cnt_reset !== 1'b0 || cnt_value !== 4'd0) begin failures++; $display("FAIL rel_idle got=%b/%0d exp=0/0", cnt_reset, cnt_value); end
  endtask

  task automatic test_count_up();
    do_cmd(4'd3, 4'd7, 1'b0, 0, 0, 1'b0);
    checks++; if (obs_done_at !== 6) begin failures++; $display("FAIL up_done_cycle got=%0d exp=6", obs_done_at); end
    checks++; if (obs_done_cnt !== 1) begin failures++; $display("FAIL up_done_pulses got=%0d exp=1", obs_done_cnt); end
    checks++; if (obs_steps_done !== 4'd4) begin failures++; $display("FAIL up_steps_at_done got=%0d exp=4", obs_steps_done); end
    checks++; if (obs_final_val !== 4'd7 || obs_final_steps !== 4'd4) begin failures++; $display("FAIL up_frozen got=%0d/%0d exp=7/4", obs_final_val, obs_final_steps); end
    checks++; if (obs_busy_cnt !== 6 || obs_ready_bad !== 0) begin failures++; $display("FAIL up_busy got=%0d/%0d exp=6/0", obs_busy_cnt, obs_ready_bad); end
  endtask

  task automatic test_count_down_wrap();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'd1; exp_seq[1] = 4'd0; exp_seq[2] = 4'd11; exp_seq[3] = 4'd10;
    do_cmd(4'd1, 4'd10, 1'b1, 0, 0, 1'b0);
    checks++; if (obs_done_at !== 5 || obs_steps_done !== 4'd3) begin failures++; $display("FAIL dn_done got=%0d/%0d exp=5/3", obs_done_at, obs_steps_done); end
    checks++; if (obs_seq.size() !== 4) begin failures++; $display("FAIL dn_seq_len got=%0d exp=4", obs_seq.size()); end
    for (int i = 0; i < 4 && i < obs_seq.size(); i++) begin
      checks++; if (obs_seq[i] !== exp_seq[i]) begin failures++; $display("FAIL dn_seq[%0d] got=%0d exp=%0d", i, obs_seq[i], exp_seq[i]); end
    end
    checks++; if (obs_final_val !== 4'd10) begin failures++; $display("FAIL dn_frozen got=%0d exp=10", obs_final_val); end
  endtask

  task automatic test_same_start_target();
    do_cmd(4'd5, 4'd5, 1'b0, 0, 0, 1'b0);
    checks++; if (obs_done_at !== 2 || obs_steps_done !== 4'd0) begin failures++; $display("FAIL same_done got=%0d/%0d exp=2/0", obs_done_at, obs_steps_done); end
    checks++; if (obs_final_val !== 4'd5) begin failures++; $display("FAIL same_frozen got=%0d exp=5", obs_final_val); end
  endtask

  task automatic test_cmd_err();
    do_cmd(4'd2, 4'd12, 1'b0, 0, 0, 1'b0);
    checks++; if (obs_err_cnt !== 1 || obs_err_at !== 1) begin failures++; $display("FAIL err_pulse got=%0d@%0d exp=1@1", obs_err_cnt, obs_err_at); end
    checks++; if (obs_busy_cnt !== 0) begin failures++; $display("FAIL err_no_load got=%0d exp=0", obs_busy_cnt); end
    checks++; if (obs_final_val !== 4'd5 || obs_final_steps !== 4'd0) begin failures++; $display("FAIL err_unchanged got=%0d/%0d exp=5/0", obs_final_val, obs_final_steps); end
    do_cmd(4'd13, 4'd3, 1'b1, 0, 0, 1'b0);
    checks++; if (obs_err_cnt !== 1 || obs_busy_cnt !== 0) begin failures++; $display("FAIL err_start got=%0d/%0d exp=1/0", obs_err_cnt, obs_busy_cnt); end
  endtask

  task automatic test_abort();
    do_cmd(4'd0, 4'd11, 1'b0, 6, 0, 1'b0);
    checks++; if (obs_done_cnt !== 0) begin failures++; $display("FAIL abort_run_done got=%0d exp=0", obs_done_cnt); end
    checks++; if (obs_final_val !== 4'd4 || obs_final_steps !== 4'd4) begin failures++; $display("FAIL abort_run_frozen got=%0d/%0d exp=4/4", obs_final_val, obs_final_steps); end
    checks++; if (obs_busy_cnt !== 6) begin failures++; $display("FAIL abort_run_busy got=%0d exp=6", obs_busy_cnt); end
    do_cmd(4'd2, 4'd9, 1'b1, 1, 0, 1'b0);
    checks++; if (obs_done_cnt !== 0 || obs_final_val !== 4'd2 || obs_final_steps !== 4'd0 || obs_busy_cnt !== 1) begin
      failures++; $display("FAIL abort_load got=%0d/%0d/%0d/%0d exp=0/2/0/1", obs_done_cnt, obs_final_val, obs_final_steps, obs_busy_cnt);
    end
    do_cmd(4'd6, 4'd8, 1'b0, 4, 0, 1'b0);
    checks++; if (obs_done_cnt !== 0 || obs_final_val !== 4'd8 || obs_final_steps !== 4'd2) begin
      failures++; $display("FAIL abort_priority got=%0d/%0d/%0d exp=0/8/2", obs_done_cnt, obs_final_val, obs_final_steps);
    end
    @(negedge clk); abort = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || cnt_value !== 4'd8) begin failures++; $display("FAIL abort_idle got=%b/%0d exp=0/8", busy, cnt_value); end
    abort = 1'b0;
  endtask

  task automatic test_mismatch();
    do_cmd(4'd0, 4'd8, 1'b0, 0, 3, 1'b0);
    checks++; if (obs_final_mm !== 1'b1) begin failures++; $display("FAIL mm_sticky got=%b exp=1", obs_final_mm); end
    checks++; if (obs_done_at !== 10 || obs_steps_done !== 4'd8) begin failures++; $display("FAIL mm_seq_unchanged got=%0d/%0d exp=10/8", obs_done_at, obs_steps_done); end
    checks++; if (obs_final_val !== 4'd8) begin failures++; $display("FAIL mm_frozen got=%0d exp=8", obs_final_val); end
    do_cmd(4'd8, 4'd9, 1'b0, 0, 0, 1'b0);
    checks++; if (obs_final_mm !== 1'b0 || obs_final_val !== 4'd9) begin failures++; $display("FAIL mm_cleared got=%b/%0d exp=0/9", obs_final_mm, obs_final_val); end
  endtask

  task automatic test_reset_midrun();
    int hi_cnt;
    int done_seen;
    hi_cnt = 0; done_seen = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_start = 4'd0; cmd_target = 4'd11; cmd_dir = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); force_req = 1'b1; force_val = 4'd7;
    @(negedge clk); force_req = 1'b0;
    @(negedge clk); #1;
    checks++; if (mismatch !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_mm_set got=%b/%b exp=1/1", mismatch, busy); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0 || cmd_err !== 1'b0) begin
      failures++; $display("FAIL mid_rst_ctrl got=%b%b%b%b exp=0100", busy, cmd_ready, done, cmd_err);
    end
    checks++; if (mismatch !== 1'b0 || steps !== 4'd0 || cnt_reset !== 1'b1) begin
      failures++; $display("FAIL mid_rst_state got=%b/%0d/%b exp=0/0/1", mismatch, steps, cnt_reset);
    end
    repeat (2) @(posedge clk); #1;
    checks++; if (cnt_value !== 4'd0) begin failures++; $display("FAIL mid_rst_counter got=%0d exp=0", cnt_value); end
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (cnt_reset) hi_cnt++;
      if (done) done_seen++;
    end
    checks++; if (hi_cnt !== 0 || done_seen !== 0) begin failures++; $display("FAIL mid_release got=%0d/%0d exp=0/0", hi_cnt, done_seen); end
    checks++; if (cnt_value !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL mid_idle_hold got=%0d/%b exp=0/0", cnt_value, busy); end
  endtask

  task automatic test_random();
    logic [3:0] s, t;
    logic       d;
    bit         bad;
    int         dd, ab, n;
    exp_hold  = 4'd0;
    exp_steps = 4'd0;
    for (int it = 0; it < 30; it++) begin
      s = 4'($urandom_range(0, 11));
      t = 4'($urandom_range(0, 11));
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 1) s = 4'($urandom_range(12, 15));
        else t = 4'($urandom_range(12, 15));
      end
      bad = (s > 4'd11) || (t > 4'd11);
      dd  = bad ? 0 : dist12(int'(s), int'(t), d);
      ab  = (!bad && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 + dd)) : 0;
      do_cmd(s, t, d, ab, 0, !bad);
      if (bad) begin
        checks++; if (obs_err_cnt !== 1 || obs_busy_cnt !== 0) begin failures++; $display("FAIL rnd%0d_err got=%0d/%0d exp=1/0", it, obs_err_cnt, obs_busy_cnt); end
      end else begin
        if (ab == 0) begin
          checks++; if (obs_done_at !== 2 + dd || obs_steps_done !== 4'(dd) || obs_done_cnt !== 1) begin
            failures++; $display("FAIL rnd%0d_done got=%0d/%0d/%0d exp=%0d/%0d/1", it, obs_done_at, obs_steps_done, obs_done_cnt, 2 + dd, dd);
          end
          exp_hold  = t;
          exp_steps = 4'(dd);
        end else begin
          n = (ab >= 2) ? ab - 2 : 0;
          checks++; if (obs_done_cnt !== 0) begin failures++; $display("FAIL rnd%0d_abort_done got=%0d exp=0", it, obs_done_cnt); end
          exp_hold  = 4'(walk12(int'(s), d, n));
          exp_steps = 4'(n);
        end
        checks++; if (obs_err_cnt !== 0 || obs_ready_bad !== 0 || obs_final_mm !== 1'b0) begin
          failures++; $display("FAIL rnd%0d_busy_ignore got=%0d/%0d/%b exp=0/0/0", it, obs_err_cnt, obs_ready_bad, obs_final_mm);
        end
      end
      checks++; if (obs_final_val !== exp_hold || obs_final_steps !== exp_steps) begin
        failures++; $display("FAIL rnd%0d_final got=%0d/%0d exp=%0d/%0d", it, obs_final_val, obs_final_steps, exp_hold, exp_steps);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down_wrap();
    test_same_start_target();
    test_cmd_err();
    test_abort();
    test_mismatch();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
